// File: rtl/alu_rr_sequencer.sv
// Round-robin shared 4-bit ALU with a 4-iteration restoring divider and valid/ready handshakes.
// Optional statistics counters are enabled by defining ALU_STATS_EN.
module alu_rr_sequencer #(
  parameter logic [7:0] DIV_ZERO_VAL = 8'hFF
`ifdef ALU_STATS_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_data,
  output logic       resp_id,
  output logic       resp_err
`ifdef ALU_STATS_EN
  ,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt,
  output logic [CNT_W-1:0] dz_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

  state_t     state;
  logic       last;
  logic       id_r;
  logic [2:0] op_r;
  logic [3:0] a_r, b_r;
  logic [3:0] rem, quo;
  logic [1:0] cnt;

  logic       grant0, grant1, accept, sel_id;
  logic [2:0] sel_op;
  logic [3:0] sel_a, sel_b;
  logic [4:0] shifted;
  logic [3:0] diff, rem_next, quo_next;
  logic       take, div_zero;
  logic [7:0] alu_res;

  // The requester that did not win last time gets priority when both are valid.
  always_comb begin
    grant0  = req0_valid & (~req1_valid | last);
    grant1  = req1_valid & (~req0_valid | ~last);
    accept  = (state == IDLE) & (grant0 | grant1);
    sel_id  = grant1;
    sel_op  = grant1 ? req1_op : req0_op;
    sel_a   = grant1 ? req1_a  : req0_a;
    sel_b   = grant1 ? req1_b  : req0_b;
  end

  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;

  // The partial remainder stays below the divisor, so a 4-bit subtract is exact when taken.
  always_comb begin
    shifted  = {rem, quo[3]};
    take     = shifted >= {1'b0, b_r};
    diff     = shifted[3:0] - b_r;
    rem_next = take ? diff : shifted[3:0];
    quo_next = {quo[2:0], take};
  end

  always_comb begin
    div_zero = (op_r == 3'd5) & (b_r == 4'd0);
    case (op_r)
      3'd0:    alu_res = {4'h0, a_r & b_r};
      3'd1:    alu_res = {4'h0, a_r} - {4'h0, b_r};
      3'd2:    alu_res = {4'h0, a_r} + {4'h0, b_r};
      3'd3:    alu_res = {4'h0, a_r | b_r};
      3'd4:    alu_res = {4'h0, a_r ^ b_r};
      3'd6:    alu_res = {4'h0, ~a_r};
      3'd7:    alu_res = {4'h0, ~b_r};
      default: alu_res = DIV_ZERO_VAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 1'b1;
      id_r       <= 1'b0;
      op_r       <= 3'd0;
      a_r        <= 4'd0;
      b_r        <= 4'd0;
      rem        <= 4'd0;
      quo        <= 4'd0;
      cnt        <= 2'd0;
      resp_valid <= 1'b0;
      resp_data  <= 8'd0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r  <= sel_op;
          a_r   <= sel_a;
          b_r   <= sel_b;
          id_r  <= sel_id;
          last  <= sel_id;
          rem   <= 4'd0;
          quo   <= sel_a;
          cnt   <= 2'd0;
          state <= (sel_op == 3'd5 && sel_b != 4'd0) ? DIV : EXEC;
        end
        EXEC: begin
          resp_data  <= alu_res;
          resp_err   <= div_zero;
          resp_id    <= id_r;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DIV: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            resp_data  <= {4'h0, quo_next};
            resp_err   <= 1'b0;
            resp_id    <= id_r;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_STATS_EN
  // Counters advance only on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done0_cnt <= '0;
      done1_cnt <= '0;
      dz_cnt    <= '0;
    end else if (resp_valid && resp_ready) begin
      if (resp_id) done1_cnt <= done1_cnt + 1'b1;
      else         done0_cnt <= done0_cnt + 1'b1;
      if (resp_err) dz_cnt <= dz_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench for alu_rr_sequencer: accepted commands push expected results,
// response handshakes pop and compare them.
module tb_alu_rr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [2:0] req0_op;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [2:0] req1_op;
  logic [3:0] req1_a, req1_b;
  logic       resp_valid, resp_ready;
  logic [7:0] resp_data;
  logic       resp_id, resp_err;
`ifdef ALU_STATS_EN
  logic [7:0] done0_cnt, done1_cnt, dz_cnt;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       id;
    logic       err;
  } exp_t;

  exp_t sb[$];
  logic grant_q[$];
  int   acc_cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic tb_last = 1'b1;

  alu_rr_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .resp_err(resp_err)
`ifdef ALU_STATS_EN
    , .done0_cnt(done0_cnt), .done1_cnt(done1_cnt), .dz_cnt(dz_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input logic id);
    exp_t e;
    logic [7:0] x, y;
    x = {4'h0, a};
    y = {4'h0, b};
    e.id = id;
    e.err = 1'b0;
    case (op)
      3'd0: e.data = x & y;
      3'd1: e.data = x - y;
      3'd2: e.data = x + y;
      3'd3: e.data = x | y;
      3'd4: e.data = x ^ y;
      3'd5: if (b == 4'd0) begin e.data = 8'hFF; e.err = 1'b1; end else e.data = x / y;
      3'd6: e.data = {4'h0, ~a};
      default: e.data = {4'h0, ~b};
    endcase
    return e;
  endfunction

  // Mid-cycle monitor: records accepts into the scoreboard and checks every response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_last = 1'b1;
    end else begin
      if (req0_valid && req0_ready) begin
        sb.push_back(model(req0_op, req0_a, req0_b, 1'b0));
        grant_q.push_back(1'b0);
        acc_cyc_q.push_back(cyc);
        tb_last = 1'b0;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(model(req1_op, req1_a, req1_b, 1'b1));
        grant_q.push_back(1'b1);
        acc_cyc_q.push_back(cyc);
        tb_last = 1'b1;
      end
      if (resp_valid && resp_ready) begin
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL resp_unexpected: got data=%h id=%0d err=%0d, required no response",
                   resp_data, resp_id, resp_err);
        end else begin
          e = sb.pop_front();
          if (resp_data !== e.data || resp_id !== e.id || resp_err !== e.err) begin
            errors++;
            $display("[TB] FAIL resp_data: got data=%h id=%0d err=%0d, required data=%h id=%0d err=%0d",
                     resp_data, resp_id, resp_err, e.data, e.id, e.err);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      output bit ok);
    int t = 0;
    if (id == 1'b0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    #1;
    while (((id == 1'b0) ? req0_ready : req1_ready) !== 1'b1 && t < 30) begin
      @(posedge clk);
      #2;
      t++;
    end
    ok = (t < 30);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    resp_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_err} !== 5'b0 || resp_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got r0=%b r1=%b v=%b d=%h id=%b e=%b, required all 0",
               req0_ready, req1_ready, resp_valid, resp_data, resp_id, resp_err);
    end
`ifdef ALU_STATS_EN
    checks++;
    if (done0_cnt !== 8'd0 || done1_cnt !== 8'd0 || dz_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters: got %0d %0d %0d, required 0 0 0", done0_cnt, done1_cnt, dz_cnt);
    end
`endif
    rst_n = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_grant: got r0=%b r1=%b, required r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  task automatic test_single_op();
    bit ok;
    int lat;
    resp_ready = 1'b1;
    send(1'b0, 3'd2, 4'd9, 4'd8, ok);
    wait_resp(lat);
    checks++;
    if (!ok || lat != 2 || resp_data !== 8'h11 || resp_id !== 1'b0 || resp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_latency: got ok=%0d lat=%0d data=%h id=%b err=%b, required ok=1 lat=2 data=11 id=0 err=0",
               ok, lat, resp_data, resp_id, resp_err);
    end
    step();
  endtask

  task automatic test_div();
    bit ok;
    int lat;
    resp_ready = 1'b1;
    send(1'b1, 3'd5, 4'd13, 4'd3, ok);
    wait_resp(lat);
    checks++;
    if (!ok || lat != 5 || resp_data !== 8'h04 || resp_id !== 1'b1 || resp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL div_latency: got ok=%0d lat=%0d data=%h id=%b err=%b, required ok=1 lat=5 data=04 id=1 err=0",
               ok, lat, resp_data, resp_id, resp_err);
    end
    step();
    send(1'b1, 3'd5, 4'd7, 4'd0, ok);
    wait_resp(lat);
    checks++;
    if (!ok || lat != 2 || resp_data !== 8'hFF || resp_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL div_zero: got ok=%0d lat=%0d data=%h err=%b, required ok=1 lat=2 data=FF err=1",
               ok, lat, resp_data, resp_err);
    end
    step();
  endtask

  task automatic test_round_robin();
    int n0, t;
    logic exp_g;
    resp_ready = 1'b1;
    grant_q.delete();
    acc_cyc_q.delete();
    exp_g = ~tb_last;
    req0_op = 3'd1; req0_a = 4'h2; req0_b = 4'h5;
    req1_op = 3'd4; req1_a = 4'hF; req1_b = 4'h3;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n0 = 0;
    t = 0;
    while (grant_q.size() < 4 && t < 40) begin
      step();
      t++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (grant_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL rr_count: got %0d accepts, required 4", grant_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_q[i] !== exp_g) begin
          errors++;
          $display("[TB] FAIL rr_grant%0d: got id=%b, required id=%b", i, grant_q[i], exp_g);
        end
        if (i > 0) begin
          checks++;
          n0 = acc_cyc_q[i] - acc_cyc_q[i-1];
          if (n0 != 3) begin
            errors++;
            $display("[TB] FAIL rr_spacing%0d: got %0d cycles, required 3", i, n0);
          end
        end
        exp_g = ~exp_g;
      end
    end
    repeat (4) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    resp_ready = 1'b0;
    send(1'b0, 3'd0, 4'hC, 4'hA, ok);
    wait_resp(lat);
    req1_op = 3'd2; req1_a = 4'd1; req1_b = 4'd1; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h08 || resp_id !== 1'b0 || resp_err !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold%0d: got v=%b d=%h id=%b e=%b r0=%b r1=%b, required v=1 d=08 id=0 e=0 r0=0 r1=0",
                 i, resp_valid, resp_data, resp_id, resp_err, req0_ready, req1_ready);
      end
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release: got v=%b r1=%b, required v=0 r1=1", resp_valid, req1_ready);
    end
    step();
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    wait_resp(lat);
    checks++;
    if (lat != 2 || resp_data !== 8'h02 || resp_id !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_release: got lat=%0d data=%h id=%b, required lat=2 data=02 id=1",
               lat, resp_data, resp_id);
    end
    step();
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit seen = 1'b0;
    resp_ready = 1'b1;
    send(1'b1, 3'd5, 4'd13, 4'd3, ok);
    step();
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_err} !== 5'b0 || resp_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got r0=%b r1=%b v=%b d=%h id=%b e=%b, required all 0",
               req0_ready, req1_ready, resp_valid, resp_data, resp_id, resp_err);
    end
    sb.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL abort_response: got resp_valid=1 after reset, required none");
    end
  endtask

`ifdef ALU_STATS_EN
  task automatic test_stats();
    bit ok;
    int lat;
    checks++;
    if (done0_cnt !== 8'd0 || done1_cnt !== 8'd0 || dz_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL stats_reset: got %0d %0d %0d, required 0 0 0", done0_cnt, done1_cnt, dz_cnt);
    end
    resp_ready = 1'b1;
    send(1'b0, 3'd2, 4'd1, 4'd1, ok); wait_resp(lat); step();
    send(1'b1, 3'd5, 4'd4, 4'd0, ok); wait_resp(lat); step();
    send(1'b0, 3'd3, 4'd1, 4'd2, ok); wait_resp(lat); step();
    step();
    checks++;
    if (done0_cnt + done1_cnt !== 8'd3 || done0_cnt !== 8'd2 || dz_cnt !== 8'd1) begin
      errors++;
      $display("[TB] FAIL stats_count: got d0=%0d d1=%0d dz=%0d, required d0=2 d1=1 dz=1",
               done0_cnt, done1_cnt, dz_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
    resp_ready = 1'b0;
    test_reset();
    test_single_op();
    test_div();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
`ifdef ALU_STATS_EN
    test_stats();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL final_drain: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_sequencer.md
Name: alu_rr_sequencer

Overview:
Shares one 4-bit ALU datapath between two requesters using a round-robin arbiter with valid/ready handshakes.
Accepts one command at a time: 3-bit op code plus 4-bit operands a and b.
Single-cycle ops complete in one execute cycle. DIV runs as a 4-iteration restoring divider.
Returns an 8-bit result tagged with the requester ID, and holds it until the consumer accepts it.

Parameters:
DIV_ZERO_VAL, 8'hFF, result value returned for DIV when b==0
CNT_W, 8, width of statistics counters (used only with ALU_STATS_EN)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted this cycle when valid&ready
req0_op  in  3  requester 0 op code
req0_a  in  4  requester 0 operand a
req0_b  in  4  requester 0 operand b
req1_valid, req1_ready, req1_op, req1_a, req1_b  (same as requester 0, for requester 1)
resp_valid  out  1  result valid
resp_ready  in  1  consumer accepts result
resp_data  out  8  result
resp_id  out  1  requester that issued the command
resp_err  out  1  DIV with b==0

Behaviour:
- Reset is asynchronous and active-low on rst_n. While reset is asserted:
  - all outputs are 0;
  - state=IDLE;
  - round-robin pointer last=1, so requester 0 wins first.
- Op semantics (a, b zero-extended to 8 bits; results mod 256):
  - 0 = a&b
  - 1 = a-b (two's-complement wrap; 2-5 gives 8'hFD)
  - 2 = a+b
  - 3 = a|b
  - 4 = a^b
  - 5 = a/b (quotient)
  - 6 = {4'b0,~a}
  - 7 = {4'b0,~b}
- States: IDLE, EXEC, DIV, DONE.
- IDLE arbitration (combinational grant):
  - only one valid: that requester is granted;
  - both valid: the requester != last is granted;
  - reqN_ready = (state==IDLE) & grantN, so at most one ready is high.
- On accept in cycle N:
  - operands, op and ID are latched;
  - last <= granted ID;
  - next state: DIV if op==5 and b!=0, else EXEC.
- EXEC (one cycle):
  - computes the result into the resp registers;
  - resp_err = (op==5 & b==0); in that case resp_data = DIV_ZERO_VAL;
  - next state DONE. resp_valid is high from cycle N+2.
- DIV:
  - 4 cycles of restoring division, MSB first;
  - 2-bit iteration counter, exits when the count reaches 3;
  - then DONE. resp_valid is high from cycle N+5.
- DONE:
  - resp_valid=1; resp_data, resp_id and resp_err are held stable while resp_ready=0;
  - resp_valid & resp_ready moves to IDLE; resp_valid drops the next cycle.
  - No new command is accepted in the same cycle as the response handshake.
- Changes on reqN_* while not ready are ignored. No command is accepted outside IDLE.
- Reset asserted mid-operation (EXEC, DIV or DONE) aborts immediately; the in-flight command is lost and no response is issued.
- Throughput: one command per 3 cycles (non-DIV), or per 6 cycles (DIV), with resp_ready held at 1.

Optional Feature:
ALU_STATS_EN
- When defined, adds these outputs:
  - done0_cnt [CNT_W-1:0]: responses completed for requester 0;
  - done1_cnt [CNT_W-1:0]: responses completed for requester 1;
  - dz_cnt [CNT_W-1:0]: DIV-by-zero responses.
- Each counter increments on the resp_valid&resp_ready handshake, wraps modulo 2^CNT_W, and resets to 0.
- When not defined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
1. Reset with both valid high -> all outputs 0. After release, req0_ready=1 and req1_ready=0 in the first cycle.
2. req0 op=2, a=9, b=8, resp_ready=1, accepted at N -> resp_valid at N+2 with resp_data=8'h11, resp_id=0, resp_err=0.
3. Both requesters hold valid for 4 commands (req0 op=1 a=2 b=5; req1 op=4 a=F b=3) -> grants alternate 0,1,0,1; results 8'hFD and 8'h0C.
4. req1 op=5, a=13, b=3 accepted at N -> resp_valid at N+5 with resp_data=8'h04, resp_id=1. With op=5, b=0 instead -> resp at N+2 with data=8'hFF, err=1.
5. resp_ready=0 for 10 cycles in DONE -> resp held stable, both ready=0. Pulse resp_ready -> IDLE and a new accept possible the next cycle.
6. Assert rst_n low during DIV iteration 2 -> outputs 0 asynchronously, no response after release. With ALU_STATS_EN, counters read 0; after 3 handshakes including 1 div-by-zero, done0_cnt+done1_cnt=3 and dz_cnt=1.
